stopwatch_bcd_counter: RTL and testbench
========================================

// Module: stopwatch_bcd_counter
// PURPOSE
//  Downstream consumer of the divided slow tick from the clock divider stage.
//  Edge-detects the tick level, optionally prescales it, and runs an MM:SS
//  BCD stopwatch with start/stop/clear control.
//  Its four BCD digits feed the display/7-seg driver stage.
// PARAMETERS
//  TICKS_PER_SEC  1   tick_in rising edges per one-second increment; legal 1..1023
//  MIN_LIMIT      59  highest minute value before wrap to 00:00; legal 0..59
// PORTS
//  clk         in   1  system clock, same domain as the divider output
//  rst         in   1  asynchronous reset, active-high
//  tick_in     in   1  slow tick level from the divider; only rising edges count
//  start_stop  in   1  single-cycle pulse; toggles run/hold
//  clr         in   1  single-cycle pulse; returns to IDLE and zeroes the count
//  sec_lo      out  4  BCD seconds units, 0..9
//  sec_hi      out  4  BCD seconds tens, 0..5
//  min_lo      out  4  BCD minutes units, 0..9
//  min_hi      out  4  BCD minutes tens, 0..5
//  running     out  1  high while state == RUN
//  wrap        out  1  one-cycle pulse on MIN_LIMIT:59 -> 00:00
// BEHAVIOUR
//  - Interface: one clock, clk. Reset rst is asynchronous and active-high.
//  - Reset values:
//    - All digits 0, running 0, wrap 0, state IDLE, prescaler 0.
//    - tick_q = 1, so a high tick_in at reset release gives no false edge.
//  - Edge detect:
//    - tick_q <= tick_in every cycle.
//    - tick_rise = tick_in & ~tick_q (combinational).
//  - Prescaler:
//    - In RUN, each tick_rise increments pre_cnt.
//    - When pre_cnt == TICKS_PER_SEC-1 and tick_rise, pre_cnt -> 0 and sec_step = 1.
//    - When TICKS_PER_SEC == 1, every tick_rise in RUN is a sec_step.
//    - pre_cnt holds in HOLD and clears in IDLE.
//  - Latency: digits change on the clk edge where tick_rise/sec_step is true.
//    That is 1 clk after tick_in rises.
//  - FSM states: IDLE, RUN, HOLD.
//    - IDLE -start_stop-> RUN.
//    - RUN  -start_stop-> HOLD.
//    - HOLD -start_stop-> RUN.
//    - Any state -clr-> IDLE.
//  - Counting acts on the current state:
//    - RUN with tick and start_stop in the same cycle: the increment is applied, then HOLD.
//    - IDLE/HOLD with tick and start_stop in the same cycle: no increment, then RUN.
//  - Priority: rst > clr > start_stop/tick.
//    - clr in the same cycle as a tick: result is 00:00 in IDLE, no wrap.
//  - BCD carry chain on sec_step:
//    - sec_lo 9 -> 0 carries to sec_hi.
//    - sec_hi 5 -> 0 carries to min_lo.
//    - min_lo 9 -> 0 carries to min_hi.
//  - Wrap:
//    - At minutes == MIN_LIMIT and seconds == 59, the next step gives 00:00.
//    - wrap is high for exactly that one cycle, and state stays RUN.
//  - Digits never leave their legal BCD ranges. All outputs are registered.
//  - Reset mid-count: outputs go to reset values immediately, with no clk needed.
// TESTING
//  1. Reset held, tick_in=1, release, 3 clk idle -> no increment; running=0; digits 00:00.
//  2. start_stop, then 5 tick_in rises -> 00:05; each step exactly 1 clk after its edge.
//  3. Preload via 59 steps to 00:59, then 1 tick -> 01:00 (sec carry into min_lo).
//  4. MIN_LIMIT=1: run to 01:59, one tick -> 00:00, wrap high 1 cycle, running=1.
//  5. In RUN, start_stop and tick_rise same cycle at 00:07 -> 00:08, HOLD.
//     Further ticks -> stays 00:08.
//  6. clr and tick_rise same cycle at 00:30 -> 00:00, IDLE; assert rst mid-RUN -> immediate 00:00.
//  7. TICKS_PER_SEC=4: 8 rises in RUN -> 00:02; 3 rises -> 00:00.

Source files
------------

// File: rtl/stopwatch_bcd_counter.sv
// MM:SS BCD stopwatch driven by the divided slow tick.
// The tick level is edge-detected and optionally prescaled into one-second
// steps. A start/stop/clear FSM gates counting. All outputs are registered.
module stopwatch_bcd_counter #(
  parameter int TICKS_PER_SEC = 1,   // 1..1023
  parameter int MIN_LIMIT     = 59   // 0..59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clr,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       running,
  output logic       wrap
);

  localparam int            PW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]    LIM_HI  = 4'(MIN_LIMIT / 10);
  localparam logic [3:0]    LIM_LO  = 4'(MIN_LIMIT % 10);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          tick_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    sec_lo_q, sec_lo_d, sec_hi_q, sec_hi_d;
  logic [3:0]    min_lo_q, min_lo_d, min_hi_q, min_hi_d;
  logic          running_q, wrap_q, wrap_d;

  logic tick_rise, in_run, sec_step, at_limit;

  assign tick_rise = tick_in & ~tick_q;
  assign in_run    = (state_q == RUN);
  // With TICKS_PER_SEC == 1 the prescaler is pinned at 0 == PRE_MAX, so every rise steps.
  assign sec_step  = in_run & tick_rise & (pre_q == PRE_MAX);
  assign at_limit  = (min_hi_q == LIM_HI) && (min_lo_q == LIM_LO) &&
                     (sec_hi_q == 4'd5)   && (sec_lo_q == 4'd9);

  // Run/hold/idle control; clr outranks start_stop.
  always_comb begin
    state_d = state_q;
    if (clr)
      state_d = IDLE;
    else if (start_stop)
      state_d = (state_q == RUN) ? HOLD : RUN;
  end

  // Prescaler: advances on rises in RUN, holds in HOLD, cleared in IDLE or by clr.
  always_comb begin
    pre_d = pre_q;
    if (clr || state_q == IDLE)
      pre_d = '0;
    else if (in_run && tick_rise)
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
  end

  // BCD carry chain with wrap at MIN_LIMIT:59.
  always_comb begin
    sec_lo_d = sec_lo_q;
    sec_hi_d = sec_hi_q;
    min_lo_d = min_lo_q;
    min_hi_d = min_hi_q;
    wrap_d   = 1'b0;
    if (clr) begin
      sec_lo_d = '0;
      sec_hi_d = '0;
      min_lo_d = '0;
      min_hi_d = '0;
    end else if (sec_step) begin
      if (at_limit) begin
        sec_lo_d = '0;
        sec_hi_d = '0;
        min_lo_d = '0;
        min_hi_d = '0;
        wrap_d   = 1'b1;
      end else if (sec_lo_q != 4'd9) begin
        sec_lo_d = sec_lo_q + 4'd1;
      end else begin
        sec_lo_d = '0;
        if (sec_hi_q != 4'd5) begin
          sec_hi_d = sec_hi_q + 4'd1;
        end else begin
          sec_hi_d = '0;
          if (min_lo_q != 4'd9) begin
            min_lo_d = min_lo_q + 4'd1;
          end else begin
            min_lo_d = '0;
            min_hi_d = min_hi_q + 4'd1;
          end
        end
      end
    end
  end

  // State, edge detector, prescaler and digit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= 1'b1;  // a high tick at reset release is not an edge
      pre_q     <= '0;
      sec_lo_q  <= '0;
      sec_hi_q  <= '0;
      min_lo_q  <= '0;
      min_hi_q  <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_in;
      pre_q     <= pre_d;
      sec_lo_q  <= sec_lo_d;
      sec_hi_q  <= sec_hi_d;
      min_lo_q  <= min_lo_d;
      min_hi_q  <= min_hi_d;
      running_q <= (state_d == RUN);
      wrap_q    <= wrap_d;
    end
  end

  assign sec_lo  = sec_lo_q;
  assign sec_hi  = sec_hi_q;
  assign min_lo  = min_lo_q;
  assign min_hi  = min_hi_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench: dut_a (1 tick/s, wrap after 01:59), dut_b (4 ticks/s).
module tb_stopwatch_bcd_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_a = 1'b0, ss_a = 1'b0, clr_a = 1'b0;
  logic tick_b = 1'b0, ss_b = 1'b0, clr_b = 1'b0;
  logic [3:0] sl_a, sh_a, ml_a, mh_a, sl_b, sh_b, ml_b, mh_b;
  logic run_a, wrap_a, run_b, wrap_b;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stopwatch_bcd_counter #(.TICKS_PER_SEC(1), .MIN_LIMIT(1)) dut_a (
    .clk(clk), .rst(rst), .tick_in(tick_a), .start_stop(ss_a), .clr(clr_a),
    .sec_lo(sl_a), .sec_hi(sh_a), .min_lo(ml_a), .min_hi(mh_a),
    .running(run_a), .wrap(wrap_a));

  stopwatch_bcd_counter #(.TICKS_PER_SEC(4), .MIN_LIMIT(59)) dut_b (
    .clk(clk), .rst(rst), .tick_in(tick_b), .start_stop(ss_b), .clr(clr_b),
    .sec_lo(sl_b), .sec_hi(sh_b), .min_lo(ml_b), .min_hi(mh_b),
    .running(run_b), .wrap(wrap_b));

  wire [15:0] dig_a = {mh_a, ml_a, sh_a, sl_a};
  wire [15:0] dig_b = {mh_b, ml_b, sh_b, sl_b};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic tick_a_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 tick_a = 1'b1;
      @(posedge clk); #1 tick_a = 1'b0;
    end
  endtask

  task automatic tick_b_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 tick_b = 1'b1;
      @(posedge clk); #1 tick_b = 1'b0;
    end
  endtask

  task automatic ss_a_pulse();
    @(posedge clk); #1 ss_a = 1'b1;
    @(posedge clk); #1 ss_a = 1'b0;
  endtask

  initial begin
    // 1. reset held with tick high, release, no false edge
    tick_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_digits", 32'(dig_a), 32'(bcd(0, 0)));
    chk("rst_running", 32'(run_a), 32'd0);
    chk("rst_wrap", 32'(wrap_a), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_no_edge", 32'(dig_a), 32'(bcd(0, 0)));
    chk("idle_running", 32'(run_a), 32'd0);
    tick_a = 1'b0;

    // 2. start, five ticks with one-clock latency each
    ss_a_pulse();
    chk("run_after_start", 32'(run_a), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1 tick_a = 1'b1;
      @(negedge clk);
      chk("lat_before", 32'(dig_a), 32'(bcd(0, i - 1)));
      @(posedge clk); #1 tick_a = 1'b0;
      chk("lat_after", 32'(dig_a), 32'(bcd(0, i)));
    end

    // 3. seconds carry into minutes
    tick_a_n(54);
    chk("at_00_59", 32'(dig_a), 32'(bcd(0, 59)));
    tick_a_n(1);
    chk("carry_01_00", 32'(dig_a), 32'(bcd(1, 0)));

    // 4. wrap from 01:59 with MIN_LIMIT=1
    tick_a_n(59);
    chk("at_01_59", 32'(dig_a), 32'(bcd(1, 59)));
    @(posedge clk); #1 tick_a = 1'b1;
    @(posedge clk); #1 tick_a = 1'b0;
    chk("wrap_digits", 32'(dig_a), 32'(bcd(0, 0)));
    chk("wrap_pulse", 32'(wrap_a), 32'd1);
    chk("wrap_running", 32'(run_a), 32'd1);
    @(posedge clk); #1;
    chk("wrap_one_cycle", 32'(wrap_a), 32'd0);

    // 5. start_stop and tick together in RUN: count, then HOLD
    tick_a_n(7);
    chk("at_00_07", 32'(dig_a), 32'(bcd(0, 7)));
    @(posedge clk); #1 tick_a = 1'b1; ss_a = 1'b1;
    @(posedge clk); #1 tick_a = 1'b0; ss_a = 1'b0;
    chk("ss_tick_count", 32'(dig_a), 32'(bcd(0, 8)));
    chk("ss_tick_hold", 32'(run_a), 32'd0);
    tick_a_n(3);
    chk("hold_frozen", 32'(dig_a), 32'(bcd(0, 8)));

    // tick with start_stop in HOLD: no count, back to RUN
    @(posedge clk); #1 tick_a = 1'b1; ss_a = 1'b1;
    @(posedge clk); #1 tick_a = 1'b0; ss_a = 1'b0;
    chk("hold_ss_tick_nocount", 32'(dig_a), 32'(bcd(0, 8)));
    chk("hold_ss_tick_run", 32'(run_a), 32'd1);

    // 6. clr with tick at 00:30, then asynchronous reset mid-run
    tick_a_n(22);
    chk("at_00_30", 32'(dig_a), 32'(bcd(0, 30)));
    @(posedge clk); #1 tick_a = 1'b1; clr_a = 1'b1;
    @(posedge clk); #1 tick_a = 1'b0; clr_a = 1'b0;
    chk("clr_digits", 32'(dig_a), 32'(bcd(0, 0)));
    chk("clr_idle", 32'(run_a), 32'd0);
    chk("clr_no_wrap", 32'(wrap_a), 32'd0);
    tick_a_n(2);
    chk("idle_ignores_tick", 32'(dig_a), 32'(bcd(0, 0)));
    ss_a_pulse();
    tick_a_n(3);
    chk("restart_00_03", 32'(dig_a), 32'(bcd(0, 3)));
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_digits", 32'(dig_a), 32'(bcd(0, 0)));
    chk("async_rst_running", 32'(run_a), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 7. prescaler of 4 on dut_b
    @(posedge clk); #1 ss_b = 1'b1;
    @(posedge clk); #1 ss_b = 1'b0;
    chk("b_running", 32'(run_b), 32'd1);
    tick_b_n(3);
    chk("b_3_rises", 32'(dig_b), 32'(bcd(0, 0)));
    tick_b_n(1);
    chk("b_4_rises", 32'(dig_b), 32'(bcd(0, 1)));
    tick_b_n(4);
    chk("b_8_rises", 32'(dig_b), 32'(bcd(0, 2)));
    chk("a_untouched", 32'(dig_a), 32'(bcd(0, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
